// File: rtl/demux_buf.sv
// demux_buf: buffered 1-to-2 demultiplexer.
// A single producer stream is steered per beat by in_sel into one of two
// independent FIFOs, so a stalled consumer never blocks the other output.
module demux_buf #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    // producer side
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_sel,
    // consumer 0
    output logic                    out0_valid,
    input  logic                    out0_ready,
    output logic [WIDTH-1:0]        out0_data,
    // consumer 1
    output logic                    out1_valid,
    input  logic                    out1_ready,
    output logic [WIDTH-1:0]        out1_data,
    // occupancy
    output logic [$clog2(DEPTH):0]  cnt0,
    output logic [$clog2(DEPTH):0]  cnt1
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // FIFO 0 state
    logic [WIDTH-1:0] mem0_q [DEPTH];
    logic [PTR_W-1:0] wr0_q, wr0_d;
    logic [PTR_W-1:0] rd0_q, rd0_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;

    // FIFO 1 state
    logic [WIDTH-1:0] mem1_q [DEPTH];
    logic [PTR_W-1:0] wr1_q, wr1_d;
    logic [PTR_W-1:0] rd1_q, rd1_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic full0, full1;
    logic push0, push1;
    logic pop0, pop1;

    // Handshake decode; in_ready depends only on in_sel and registered fullness.
    always_comb begin
        full0      = (cnt0_q == CNT_W'(DEPTH));
        full1      = (cnt1_q == CNT_W'(DEPTH));
        in_ready   = in_sel ? !full1 : !full0;
        push0      = in_valid & in_ready & !in_sel;
        push1      = in_valid & in_ready & in_sel;
        out0_valid = (cnt0_q != '0);
        out1_valid = (cnt1_q != '0);
        pop0       = out0_valid & out0_ready;
        pop1       = out1_valid & out1_ready;
        out0_data  = mem0_q[rd0_q];
        out1_data  = mem1_q[rd1_q];
        cnt0       = cnt0_q;
        cnt1       = cnt1_q;
    end

    // Next-state for pointers and occupancy of both FIFOs.
    always_comb begin
        wr0_d  = wr0_q;
        rd0_d  = rd0_q;
        cnt0_d = cnt0_q;
        wr1_d  = wr1_q;
        rd1_d  = rd1_q;
        cnt1_d = cnt1_q;

        if (push0) wr0_d = wr0_q + PTR_W'(1);
        if (pop0)  rd0_d = rd0_q + PTR_W'(1);
        case ({push0, pop0})
            2'b10:   cnt0_d = cnt0_q + CNT_W'(1);
            2'b01:   cnt0_d = cnt0_q - CNT_W'(1);
            default: cnt0_d = cnt0_q;
        endcase

        if (push1) wr1_d = wr1_q + PTR_W'(1);
        if (pop1)  rd1_d = rd1_q + PTR_W'(1);
        case ({push1, pop1})
            2'b10:   cnt1_d = cnt1_q + CNT_W'(1);
            2'b01:   cnt1_d = cnt1_q - CNT_W'(1);
            default: cnt1_d = cnt1_q;
        endcase
    end

    // Control registers; reset discards all buffered beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr0_q  <= '0;
            rd0_q  <= '0;
            cnt0_q <= '0;
            wr1_q  <= '0;
            rd1_q  <= '0;
            cnt1_q <= '0;
        end else begin
            wr0_q  <= wr0_d;
            rd0_q  <= rd0_d;
            cnt0_q <= cnt0_d;
            wr1_q  <= wr1_d;
            rd1_q  <= rd1_d;
            cnt1_q <= cnt1_d;
        end
    end

    // Payload storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push0) mem0_q[wr0_q] <= in_data;
        if (push1) mem1_q[wr1_q] <= in_data;
    end

endmodule

// File: tb/tb_demux_buf.sv
// tb_demux_buf: randomized self-checking bench for demux_buf against a
// queue-based reference model.
module tb_demux_buf;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, in_sel;
    logic [WIDTH-1:0] in_data;
    logic             out0_valid, out0_ready, out1_valid, out1_ready;
    logic [WIDTH-1:0] out0_data, out1_data;
    logic [1:0]       cnt0, cnt1;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];

    demux_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
        .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and update the model from the handshakes in force.
    task automatic step();
        bit rdy, psh, p0, p1;
        rdy = in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
        psh = in_valid && rdy;
        p0  = (q0.size() != 0) && out0_ready;
        p1  = (q1.size() != 0) && out1_ready;
        @(posedge clk);
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (psh) begin
            if (in_sel) q1.push_back(in_data);
            else        q0.push_back(in_data);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; in_sel = 0; in_data = '0; out0_ready = 0; out1_ready = 0;
        #12;
        checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin failures++;
            $display("FAIL reset_valid: out0_valid=%b out1_valid=%b expected 0 0", out0_valid, out1_valid); end
        checks++; if (in_ready !== 1'b1 || cnt0 !== 2'd0 || cnt1 !== 2'd0) begin failures++;
            $display("FAIL reset_ready_cnt: in_ready=%b cnt0=%0d cnt1=%0d expected 1 0 0", in_ready, cnt0, cnt1); end
        rst = 1'b0;
        @(posedge clk); #1;
        // queue two beats on out0, then reset mid-stream
        in_valid = 1; in_sel = 0; in_data = 32'hB1; step();
        in_data = 32'hB2; step();
        in_valid = 0;
        checks++; if (cnt0 !== 2'd2) begin failures++;
            $display("FAIL prereset_cnt0: got %0d expected 2", cnt0); end
        rst = 1'b1; #1;
        q0.delete(); q1.delete();
        checks++; if (out0_valid !== 1'b0 || cnt0 !== 2'd0 || in_ready !== 1'b1) begin failures++;
            $display("FAIL midreset: out0_valid=%b cnt0=%0d in_ready=%b expected 0 0 1", out0_valid, cnt0, in_ready); end
        #2; rst = 1'b0;
        @(posedge clk); #1;
        in_valid = 1; in_sel = 0; in_data = 32'hA5; step();
        in_valid = 0;
        checks++; if (out0_valid !== 1'b1 || out0_data !== 32'hA5 || cnt0 !== 2'd1) begin failures++;
            $display("FAIL post_reset_push: valid=%b data=%h cnt0=%0d expected 1 a5 1", out0_valid, out0_data, cnt0); end
        out0_ready = 1; step(); out0_ready = 0;
        checks++; if (out0_valid !== 1'b0) begin failures++;
            $display("FAIL post_reset_drain: out0_valid=%b expected 0", out0_valid); end
    endtask

    task automatic test_steering();
        out0_ready = 1; out1_ready = 1;
        in_valid = 1; in_sel = 0; in_data = 32'h11; step();
        checks++; if (out0_valid !== 1'b1 || out0_data !== 32'h11 || cnt0 !== 2'd1 || out1_valid !== 1'b0) begin failures++;
            $display("FAIL steer_cycle1: out0_valid=%b out0_data=%h cnt0=%0d out1_valid=%b expected 1 11 1 0",
                     out0_valid, out0_data, cnt0, out1_valid); end
        in_sel = 1; in_data = 32'h22; step();
        in_valid = 0;
        checks++; if (out1_valid !== 1'b1 || out1_data !== 32'h22 || cnt1 !== 2'd1 || cnt0 !== 2'd0) begin failures++;
            $display("FAIL steer_cycle2: out1_valid=%b out1_data=%h cnt1=%0d cnt0=%0d expected 1 22 1 0",
                     out1_valid, out1_data, cnt1, cnt0); end
        step();
        checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin failures++;
            $display("FAIL steer_drain: out0_valid=%b out1_valid=%b expected 0 0", out0_valid, out1_valid); end
        out0_ready = 0; out1_ready = 0;
    endtask

    task automatic test_full();
        in_valid = 1; in_sel = 0;
        in_data = 32'h1; step();
        in_data = 32'h2; step();
        in_data = 32'h3; #1;
        checks++; if (cnt0 !== 2'd2 || in_ready !== 1'b0) begin failures++;
            $display("FAIL full_backpressure: cnt0=%0d in_ready=%b expected 2 0", cnt0, in_ready); end
        in_sel = 1; in_data = 32'h44; #1;
        checks++; if (in_ready !== 1'b1) begin failures++;
            $display("FAIL full_other_port: in_ready=%b expected 1", in_ready); end
        step();
        checks++; if (out1_valid !== 1'b1 || out1_data !== 32'h44) begin failures++;
            $display("FAIL full_other_accept: out1_valid=%b out1_data=%h expected 1 44", out1_valid, out1_data); end
        // full plus pop: no accept this cycle, freed slot used next cycle
        in_sel = 0; in_data = 32'h3; out0_ready = 1; #1;
        checks++; if (in_ready !== 1'b0 || out0_data !== 32'h1) begin failures++;
            $display("FAIL full_pop_ready: in_ready=%b out0_data=%h expected 0 1", in_ready, out0_data); end
        step();
        checks++; if (cnt0 !== 2'd1 || out0_data !== 32'h2 || in_ready !== 1'b1) begin failures++;
            $display("FAIL full_pop_after: cnt0=%0d out0_data=%h in_ready=%b expected 1 2 1", cnt0, out0_data, in_ready); end
        // simultaneous push and pop with one entry
        step();
        checks++; if (cnt0 !== 2'd1 || out0_data !== 32'h3) begin failures++;
            $display("FAIL push_pop_same: cnt0=%0d out0_data=%h expected 1 3", cnt0, out0_data); end
        in_data = 32'h7; step();
        in_valid = 0;
        checks++; if (cnt0 !== 2'd1 || out0_data !== 32'h7) begin failures++;
            $display("FAIL push_pop_head: cnt0=%0d out0_data=%h expected 1 7", cnt0, out0_data); end
        out1_ready = 1; step(); step();
        checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin failures++;
            $display("FAIL full_drain: out0_valid=%b out1_valid=%b expected 0 0", out0_valid, out1_valid); end
        out0_ready = 0; out1_ready = 0;
    endtask

    task automatic test_wrap();
        int sent = 0, got = 0, errs = 0;
        in_sel = 0;
        for (int cyc = 0; cyc < 2000 && got < 100; cyc++) begin
            in_valid   = (sent < 100) && ($urandom_range(0, 3) != 0);
            in_data    = WIDTH'(sent);
            out0_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out0_valid && out0_ready) begin
                checks++; if (out0_data !== WIDTH'(got)) begin failures++; errs++;
                    if (errs < 5) $display("FAIL wrap_order: got %0d expected %0d", out0_data, got); end
                got++;
            end
            if (in_valid && in_ready) sent++;
            checks++; if (out1_valid !== 1'b0 || cnt0 > 2'd2 || cnt0 !== 2'(q0.size())) begin failures++; errs++;
                if (errs < 5) $display("FAIL wrap_state: out1_valid=%b cnt0=%0d expected 0 %0d", out1_valid, cnt0, q0.size()); end
            step();
        end
        in_valid = 0; out0_ready = 0;
        checks++; if (got != 100) begin failures++;
            $display("FAIL wrap_count: delivered %0d expected 100", got); end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid   = $urandom_range(0, 1);
            in_sel     = $urandom_range(0, 1);
            in_data    = $urandom;
            out0_ready = $urandom_range(0, 1);
            out1_ready = ($urandom_range(0, 3) == 0);
            #1;
            checks++;
            if (in_ready !== ((in_sel ? q1.size() : q0.size()) < DEPTH) ||
                cnt0 !== 2'(q0.size()) || cnt1 !== 2'(q1.size()) ||
                out0_valid !== (q0.size() != 0) || out1_valid !== (q1.size() != 0) ||
                (q0.size() != 0 && out0_data !== q0[0]) ||
                (q1.size() != 0 && out1_data !== q1[0])) begin
                failures++; errs++;
                if (errs < 5) $display("FAIL random_cyc%0d: rdy=%b cnt0=%0d cnt1=%0d d0=%h d1=%h expected cnt0=%0d cnt1=%0d",
                                       cyc, in_ready, cnt0, cnt1, out0_data, out1_data, q0.size(), q1.size());
            end
            step();
        end
        in_valid = 0; out0_ready = 0; out1_ready = 0;
    endtask

    initial begin
        test_reset();
        test_steering();
        test_full();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
